// File: rtl/icache.sv
// Direct-mapped, blocking instruction cache: one 32-bit word per line.
// Hits are answered from on-chip arrays. A miss issues one word request to the
// memory controller, fills the line, then returns the word to fetch.
module icache #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    input  logic        clear,
    output logic        fetch_valid,
    output logic [31:0] fetch_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_received,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e state_q, state_d;
    logic   drop_q, drop_d;
    logic   fetch_valid_d;
    logic [31:0] fetch_inst_d;
    logic   mem_req_d;
    logic [31:0] mem_addr_d;
    logic   fill;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      pc_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit;

    // mem_addr doubles as the latched miss pc: it holds until the next miss.
    assign idx      = fetch_pc[INDEX_BITS+1:2];
    assign pc_tag   = fetch_pc[31:INDEX_BITS+2];
    assign fill_idx = mem_addr[INDEX_BITS+1:2];
    assign fill_tag = mem_addr[31:INDEX_BITS+2];
    assign hit      = valid_q[idx] && (tag_mem[idx] == pc_tag);

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        drop_d        = drop_q;
        fetch_valid_d = 1'b0;
        fetch_inst_d  = fetch_inst;
        mem_req_d     = mem_req;
        mem_addr_d    = mem_addr;
        fill          = 1'b0;
        unique case (state_q)
            StIdle: begin
                // fetch_valid gate keeps responses at least two cycles apart.
                if (fetch_req && !fetch_valid && !clear) begin
                    if (hit) begin
                        fetch_valid_d = 1'b1;
                        fetch_inst_d  = data_mem[idx];
                    end else begin
                        mem_addr_d = {fetch_pc[31:2], 2'b00};
                        mem_req_d  = 1'b1;
                        drop_d     = 1'b0;
                        state_d    = StReq;
                    end
                end
            end
            StReq: begin
                // The controller cannot abort, so a flush only suppresses the reply.
                if (clear) drop_d = 1'b1;
                if (mem_received) begin
                    mem_req_d = 1'b0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (clear) drop_d = 1'b1;
                if (mem_done) begin
                    fill    = 1'b1;
                    state_d = StIdle;
                    if (!drop_q && !clear) begin
                        fetch_valid_d = 1'b1;
                        fetch_inst_d  = mem_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, control outputs and valid bits; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            drop_q      <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_inst  <= 32'h0;
            mem_req     <= 1'b0;
            mem_addr    <= 32'h0;
            valid_q     <= '0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            fetch_valid <= fetch_valid_d;
            fetch_inst  <= fetch_inst_d;
            mem_req     <= mem_req_d;
            mem_addr    <= mem_addr_d;
            if (fill) valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset; the valid bits guard them.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: miss, hit, conflict, flush, stall, reset.
module tb_icache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        clear;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_received;
    logic        mem_done;
    logic [31:0] mem_data;

    int checks = 0;
    int errors = 0;

    icache #(.INDEX_BITS(6)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .fetch_req    (fetch_req),
        .fetch_pc     (fetch_pc),
        .clear        (clear),
        .fetch_valid  (fetch_valid),
        .fetch_inst   (fetch_inst),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_received (mem_received),
        .mem_done     (mem_done),
        .mem_data     (mem_data)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; fetch_req = 1'b0; fetch_pc = 32'h0; clear = 1'b0;
        mem_received = 1'b0; mem_done = 1'b0; mem_data = 32'h0;
        step();
        chk("rst_fetch_valid", {31'h0, fetch_valid}, 32'h0);
        chk("rst_fetch_inst", fetch_inst, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst_in = 1'b0;
        step();

        // Cold miss at pc 0
        fetch_req = 1'b1; fetch_pc = 32'h0;
        step();
        chk("cold_mem_req", {31'h0, mem_req}, 32'h1);
        chk("cold_mem_addr", mem_addr, 32'h0);
        mem_received = 1'b1;
        step();
        chk("cold_req_drop", {31'h0, mem_req}, 32'h0);
        mem_received = 1'b0;
        step();
        mem_done = 1'b1; mem_data = 32'h0000_0013;
        step();
        chk("cold_valid", {31'h0, fetch_valid}, 32'h1);
        chk("cold_inst", fetch_inst, 32'h0000_0013);
        mem_done = 1'b0; mem_data = 32'h0; fetch_req = 1'b0;
        step();
        chk("cold_pulse_end", {31'h0, fetch_valid}, 32'h0);

        // Hit at pc 0
        fetch_req = 1'b1;
        step();
        chk("hit_valid", {31'h0, fetch_valid}, 32'h1);
        chk("hit_inst", fetch_inst, 32'h0000_0013);
        chk("hit_no_mem_req", {31'h0, mem_req}, 32'h0);
        fetch_req = 1'b0;
        step();

        // Conflict: 0x100 evicts index 0
        fetch_req = 1'b1; fetch_pc = 32'h100;
        step();
        chk("conf_mem_req", {31'h0, mem_req}, 32'h1);
        chk("conf_mem_addr", mem_addr, 32'h100);
        mem_received = 1'b1;
        step();
        mem_received = 1'b0;
        step();
        mem_done = 1'b1; mem_data = 32'hAAAA_0001;
        step();
        chk("conf_inst", fetch_inst, 32'hAAAA_0001);
        mem_done = 1'b0; fetch_req = 1'b0;
        step();
        fetch_req = 1'b1; fetch_pc = 32'h0;
        step();
        chk("refetch_miss", {31'h0, mem_req}, 32'h1);
        chk("refetch_addr", mem_addr, 32'h0);
        chk("refetch_no_valid", {31'h0, fetch_valid}, 32'h0);
        mem_received = 1'b1;
        step();
        mem_received = 1'b0;
        step();
        mem_done = 1'b1; mem_data = 32'h0000_0013;
        step();
        mem_done = 1'b0; fetch_req = 1'b0;
        step();

        // Unaligned pc, then flush during WAIT
        fetch_req = 1'b1; fetch_pc = 32'h106;
        step();
        chk("unal_mem_addr", mem_addr, 32'h104);
        mem_received = 1'b1;
        step();
        mem_received = 1'b0;
        clear = 1'b1; fetch_req = 1'b0;
        step();
        clear = 1'b0;
        mem_done = 1'b1; mem_data = 32'h1234_5678;
        step();
        chk("flush_no_valid", {31'h0, fetch_valid}, 32'h0);
        mem_done = 1'b0;
        step();
        fetch_req = 1'b1;
        step();
        chk("flush_hit_valid", {31'h0, fetch_valid}, 32'h1);
        chk("flush_hit_inst", fetch_inst, 32'h1234_5678);
        chk("flush_hit_no_req", {31'h0, mem_req}, 32'h0);
        fetch_req = 1'b0;
        step();

        // Clear coincident with mem_done
        fetch_req = 1'b1; fetch_pc = 32'h200;
        step();
        chk("sim_mem_addr", mem_addr, 32'h200);
        mem_received = 1'b1;
        step();
        mem_received = 1'b0;
        step();
        clear = 1'b1; mem_done = 1'b1; mem_data = 32'hDEAD_0000; fetch_req = 1'b0;
        step();
        chk("sim_no_valid", {31'h0, fetch_valid}, 32'h0);
        clear = 1'b0; mem_done = 1'b0;
        step();
        fetch_req = 1'b1;
        step();
        chk("sim_hit_inst", fetch_inst, 32'hDEAD_0000);
        chk("sim_hit_valid", {31'h0, fetch_valid}, 32'h1);

        // Stall while fetch_valid is high
        rdy_in = 1'b0; fetch_req = 1'b0;
        step();
        step();
        chk("stall_valid_hold", {31'h0, fetch_valid}, 32'h1);
        rdy_in = 1'b1;
        step();
        chk("stall_valid_drop", {31'h0, fetch_valid}, 32'h0);

        // Stall in REQ
        fetch_req = 1'b1; fetch_pc = 32'h300;
        step();
        chk("reqstall_req", {31'h0, mem_req}, 32'h1);
        rdy_in = 1'b0; mem_received = 1'b1;
        step();
        step();
        chk("reqstall_req_hold", {31'h0, mem_req}, 32'h1);
        chk("reqstall_addr_hold", mem_addr, 32'h300);
        mem_received = 1'b0; rdy_in = 1'b1;

        // Async reset between edges
        #2 rst_in = 1'b1;
        #1;
        chk("arst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        fetch_req = 1'b0;
        step();
        rst_in = 1'b0;
        step();
        fetch_req = 1'b1; fetch_pc = 32'h106;
        step();
        chk("arst_refetch_miss", {31'h0, mem_req}, 32'h1);
        chk("arst_refetch_addr", mem_addr, 32'h104);
        chk("arst_refetch_novalid", {31'h0, fetch_valid}, 32'h0);
        mem_received = 1'b1;
        step();
        mem_received = 1'b0;
        step();
        mem_done = 1'b1; mem_data = 32'hCAFE_F00D;
        step();
        chk("arst_fill_inst", fetch_inst, 32'hCAFE_F00D);
        chk("arst_fill_valid", {31'h0, fetch_valid}, 32'h1);
        mem_done = 1'b0; fetch_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
